fun_demux16: RTL and testbench

- Registered 1-to-16 demultiplexer.
- Steers the single-bit data input I onto one of 16 output lines, selected by a 4-bit code on S1..S4 (S1 = MSB).
- All unselected lines are driven 0.
- Used as a one-hot line driver / address-decode stage. The output is registered, so it drops into a synchronous pipeline without extra timing logic.

---
 rtl/fun_demux16_pkg.sv | 16 +
 rtl/fun_demux16_dec.sv | 20 ++
 rtl/fun_demux16.sv | 38 +++
 tb/tb_fun_demux16.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fun_demux16_pkg.sv
// Shared constants and the one-hot helper for the registered 1-to-16 demultiplexer.
package fun_demux16_pkg;

    localparam int SEL_W = 4;
    localparam int OUT_W = 16;
    localparam logic [OUT_W-1:0] OUT_RESET = 16'h0000;

    // Single set bit at position sel; every other bit clear.
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] r;
        r      = OUT_RESET;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fun_demux16_dec.sv
// Combinational 4-to-16 one-hot decoder; with en_i low every output line is 0.
module fun_demux16_dec
    import fun_demux16_pkg::*;
(
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [OUT_W-1:0] dec_o
);

    // Route the enable onto the selected line only.
    always_comb begin
        dec_o = OUT_RESET;
        if (en_i) begin
            dec_o = onehot(sel_i);
        end else begin
            dec_o = OUT_RESET;
        end
    end

endmodule

// File: rtl/fun_demux16.sv
// Registered 1-to-16 demultiplexer: I is steered to O[{S1,S2,S3,S4}] one clock later.
module fun_demux16
    import fun_demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I,
    input  logic             S1,
    input  logic             S2,
    input  logic             S3,
    input  logic             S4,
    output logic [OUT_W-1:0] O
);

    logic [SEL_W-1:0] sel_s;
    logic [OUT_W-1:0] o_d;
    logic [OUT_W-1:0] o_q;

    assign sel_s = {S1, S2, S3, S4};

    fun_demux16_dec u_dec (
        .en_i  (I),
        .sel_i (sel_s),
        .dec_o (o_d)
    );

    // Output register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q <= OUT_RESET;
        end else begin
            o_q <= o_d;
        end
    end

    assign O = o_q;

endmodule

// File: tb/tb_fun_demux16.sv
// Self-checking bench for fun_demux16: directed scenarios plus randomized traffic against a reference model.
module tb_fun_demux16;

    logic        clk;
    logic        rst_n;
    logic        I;
    logic        S1, S2, S3, S4;
    logic [15:0] O;

    int n_vec;
    int n_err;

    fun_demux16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
        .S4    (S4),
        .O     (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: line k is high only when it is the addressed line and data is 1.
    function automatic logic [15:0] ref_out(input logic rst, input logic d, input int sel);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) begin
            r[k] = (rst && d && (k == sel)) ? 1'b1 : 1'b0;
        end
        return r;
    endfunction

    task automatic drive(input logic rst, input logic d, input int sel);
        logic [3:0] s;
        s     = sel[3:0];
        rst_n = rst;
        I     = d;
        {S1, S2, S3, S4} = s;
    endtask

    // Apply inputs, clock once, then check O against the model.
    task automatic step(input string tag, input logic rst, input logic d, input int sel);
        drive(rst, d, sel);
        @(posedge clk);
        #1;
        chk(tag, O, ref_out(rst, d, sel));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive(1'b0, 1'b1, 5);
        #1;

        // Reset held two edges with I=1, sel=5, then release.
        step("reset_edge1", 1'b0, 1'b1, 5);
        chk("reset_val", O, 16'h0000);
        step("reset_edge2", 1'b0, 1'b1, 5);
        step("reset_release", 1'b1, 1'b1, 5);
        chk("release_val", O, 16'h0020);

        // Walk a single 1 across all lines.
        for (int s = 0; s < 16; s++) step($sformatf("walk_%0d", s), 1'b1, 1'b1, s);
        chk("walk_end", O, 16'h8000);
        step("wrap_0", 1'b1, 1'b1, 0);
        chk("wrap_val", O, 16'h0001);

        // Zero data on every select.
        for (int s = 0; s < 16; s++) step($sformatf("zero_%0d", s), 1'b1, 1'b0, s);

        // Mid-cycle select change must not reach O before the edge.
        step("lat_pre", 1'b1, 1'b1, 3);
        chk("lat_pre_val", O, 16'h0008);
        drive(1'b1, 1'b1, 12);
        #2;
        chk("lat_hold", O, 16'h0008);
        @(posedge clk);
        #1;
        chk("lat_post", O, 16'h1000);

        // Reset mid-stream; asserting between edges changes nothing until the edge.
        step("mid_pre", 1'b1, 1'b1, 9);
        chk("mid_pre_val", O, 16'h0200);
        drive(1'b0, 1'b1, 9);
        #2;
        chk("mid_async_hold", O, 16'h0200);
        @(posedge clk);
        #1;
        chk("mid_reset", O, 16'h0000);
        step("mid_release", 1'b1, 1'b1, 9);
        chk("mid_release_val", O, 16'h0200);

        // Toggle data on the top line.
        for (int c = 0; c < 8; c++) begin
            step($sformatf("toggle_%0d", c), 1'b1, ~c[0], 15);
            chk($sformatf("toggle_val_%0d", c), O, c[0] ? 16'h0000 : 16'h8000);
        end

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 300; c++) begin
            step($sformatf("rand_%0d", c), ($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
